// File: rtl/icm_buffer_set_del_dispatch_if.sv
// Request/issue bundle for the ICM buffer set/del dispatcher.
// The master modport is the environment side: it drives the fill/invalidate
// producers and the Set/Del thread ready pulses. The slave modport is the
// dispatcher itself.
interface icm_buffer_set_del_dispatch_if #(
    parameter int ICM_ADDR_WIDTH    = 64,
    parameter int CACHE_ENTRY_WIDTH = 256,
    parameter int QUEUE_DEPTH       = 8
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic                         fill_valid;
    logic [ICM_ADDR_WIDTH-1:0]    fill_head;
    logic [CACHE_ENTRY_WIDTH-1:0] fill_data;
    logic                         fill_ready;

    logic                         inv_valid;
    logic [ICM_ADDR_WIDTH-1:0]    inv_head;
    logic                         inv_ready;

    logic                         set_req_valid;
    logic [ICM_ADDR_WIDTH-1:0]    set_req_head;
    logic [CACHE_ENTRY_WIDTH-1:0] set_req_data;
    logic                         set_req_ready;

    logic                         del_req_valid;
    logic [ICM_ADDR_WIDTH-1:0]    del_req_head;
    logic                         del_req_ready;

    logic [CNT_W-1:0]             queue_count;

    modport master (
        output fill_valid, fill_head, fill_data,
        output inv_valid, inv_head,
        output set_req_ready, del_req_ready,
        input  fill_ready, inv_ready,
        input  set_req_valid, set_req_head, set_req_data,
        input  del_req_valid, del_req_head,
        input  queue_count
    );

    modport slave (
        input  fill_valid, fill_head, fill_data,
        input  inv_valid, inv_head,
        input  set_req_ready, del_req_ready,
        output fill_ready, inv_ready,
        output set_req_valid, set_req_head, set_req_data,
        output del_req_valid, del_req_head,
        output queue_count
    );
endinterface

// File: rtl/icm_buffer_set_del_dispatch.sv
// ICM buffer set/del dispatcher.
// Cache fills (set) and invalidates (del) are arbitrated round-robin into one
// shared circular queue, then issued one at a time, in acceptance order, to the
// Set/Del thread. Each issued request is held in registered outputs until the
// thread returns its one-cycle ready pulse.
module icm_buffer_set_del_dispatch #(
    parameter int ICM_ADDR_WIDTH    = 64,
    parameter int CACHE_ENTRY_WIDTH = 256,
    parameter int QUEUE_DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    icm_buffer_set_del_dispatch_if.slave  bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Arbitration pointer encoding: which side wins when both are valid.
    localparam logic RR_INV  = 1'b0;
    localparam logic RR_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE_SET = 2'd1,
        ISSUE_DEL = 2'd2
    } state_t;

    // Queue storage: op (1 = set, 0 = del), head, data (0 for del entries).
    logic                         op_mem   [QUEUE_DEPTH];
    logic [ICM_ADDR_WIDTH-1:0]    head_mem [QUEUE_DEPTH];
    logic [CACHE_ENTRY_WIDTH-1:0] data_mem [QUEUE_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             rr_q;

    state_t                       state_q;
    logic                         set_vld_q;
    logic [ICM_ADDR_WIDTH-1:0]    set_head_q;
    logic [CACHE_ENTRY_WIDTH-1:0] set_data_q;
    logic                         del_vld_q;
    logic [ICM_ADDR_WIDTH-1:0]    del_head_q;

    logic full;
    logic empty;
    logic grant_fill;
    logic grant_inv;
    logic acc_fill;
    logic acc_inv;
    logic accept;
    logic pop;

    // Arbitration, accept/pop decisions and next occupancy. Fullness is taken
    // from the registered count, so a pop never frees a slot in its own cycle.
    always_comb begin
        full       = (count_q == CNT_W'(QUEUE_DEPTH));
        empty      = (count_q == '0);
        grant_fill = bus.fill_valid && (!bus.inv_valid || (rr_q == RR_FILL));
        grant_inv  = bus.inv_valid  && (!bus.fill_valid || (rr_q == RR_INV));
        acc_fill   = grant_fill && !full;
        acc_inv    = grant_inv  && !full;
        accept     = acc_fill || acc_inv;
        pop        = (state_q == IDLE) && !empty;
        count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    assign bus.fill_ready    = acc_fill;
    assign bus.inv_ready     = acc_inv;
    assign bus.queue_count   = count_q;
    assign bus.set_req_valid = set_vld_q;
    assign bus.set_req_head  = set_head_q;
    assign bus.set_req_data  = set_data_q;
    assign bus.del_req_valid = del_vld_q;
    assign bus.del_req_head  = del_head_q;

    // Queue write: stale contents are never read after reset because the
    // pointers and count restart at zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_mem[wr_ptr_q]   <= acc_fill;
            head_mem[wr_ptr_q] <= acc_fill ? bus.fill_head : bus.inv_head;
            data_mem[wr_ptr_q] <= acc_fill ? bus.fill_data : '0;
        end
    end

    // Queue pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= RR_INV;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                rr_q     <= acc_inv ? RR_FILL : RR_INV;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Issue FSM with registered outputs; outputs return to zero in IDLE and a
    // ready pulse for the other request type is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            set_vld_q  <= 1'b0;
            set_head_q <= '0;
            set_data_q <= '0;
            del_vld_q  <= 1'b0;
            del_head_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        if (op_mem[rd_ptr_q]) begin
                            state_q    <= ISSUE_SET;
                            set_vld_q  <= 1'b1;
                            set_head_q <= head_mem[rd_ptr_q];
                            set_data_q <= data_mem[rd_ptr_q];
                        end else begin
                            state_q    <= ISSUE_DEL;
                            del_vld_q  <= 1'b1;
                            del_head_q <= head_mem[rd_ptr_q];
                        end
                    end
                end
                ISSUE_SET: begin
                    if (bus.set_req_ready) begin
                        state_q    <= IDLE;
                        set_vld_q  <= 1'b0;
                        set_head_q <= '0;
                        set_data_q <= '0;
                    end
                end
                ISSUE_DEL: begin
                    if (bus.del_req_ready) begin
                        state_q    <= IDLE;
                        del_vld_q  <= 1'b0;
                        del_head_q <= '0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    set_vld_q  <= 1'b0;
                    set_head_q <= '0;
                    set_data_q <= '0;
                    del_vld_q  <= 1'b0;
                    del_head_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icm_buffer_set_del_dispatch.sv
// Testbench for icm_buffer_set_del_dispatch: directed scenarios followed by
// random interleaved traffic, checked every cycle against a queue-based model.
module tb_icm_buffer_set_del_dispatch;
    localparam int AW    = 64;
    localparam int DW    = 256;
    localparam int DEPTH = 8;

    typedef struct {
        logic          op;
        logic [AW-1:0] head;
        logic [DW-1:0] data;
    } ent_t;

    logic clk;
    logic rst;

    icm_buffer_set_del_dispatch_if #(
        .ICM_ADDR_WIDTH(AW), .CACHE_ENTRY_WIDTH(DW), .QUEUE_DEPTH(DEPTH)
    ) bus ();

    icm_buffer_set_del_dispatch #(
        .ICM_ADDR_WIDTH(AW), .CACHE_ENTRY_WIDTH(DW), .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: pending queue, request currently held by the
    // issuer, round-robin preference (1 = fill preferred).
    ent_t mq[$];
    ent_t acc_log[$];
    ent_t cur;
    bit   cur_vld;
    bit   mrr;
    bit   model_ok;
    int   acc_n;

    int checks;
    int failures;

    logic          prev_set_vld, prev_del_vld;
    logic [AW-1:0] prev_set_head, prev_del_head;
    logic [DW-1:0] prev_set_data;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [AW-1:0] rnd_head();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle: inputs are already applied (at the negedge). Check the
    // DUT against the model, advance the model at the posedge, return at the
    // next negedge.
    task automatic cycle();
        bit   full, gf, gi, ef, ei, done, popd;
        bit   exp_set, exp_del;
        ent_t e;
        ent_t x;
        #1;
        full    = (mq.size() == DEPTH);
        gf      = bus.fill_valid && (!bus.inv_valid || mrr);
        gi      = bus.inv_valid && (!bus.fill_valid || !mrr);
        ef      = gf && !full;
        ei      = gi && !full;
        exp_set = cur_vld && cur.op;
        exp_del = cur_vld && !cur.op;
        if (model_ok) begin
            check_eq("fill_ready", bus.fill_ready, ef);
            check_eq("inv_ready", bus.inv_ready, ei);
            check_eq("set_req_valid", bus.set_req_valid, exp_set);
            check_eq("del_req_valid", bus.del_req_valid, exp_del);
            check_eq("set_req_head", bus.set_req_head, exp_set ? cur.head : '0);
            check_eq("set_req_data", bus.set_req_data, exp_set ? cur.data : '0);
            check_eq("del_req_head", bus.del_req_head, exp_del ? cur.head : '0);
            check_eq("queue_count", bus.queue_count, mq.size());
            check_eq("valid_overlap", bus.set_req_valid && bus.del_req_valid, 0);
            if (prev_set_vld && bus.set_req_valid) begin
                check_eq("set_head_stable", bus.set_req_head, prev_set_head);
                check_eq("set_data_stable", bus.set_req_data, prev_set_data);
            end
            if (prev_del_vld && bus.del_req_valid)
                check_eq("del_head_stable", bus.del_req_head, prev_del_head);
            // Scoreboard on what the DUT actually hands over to the thread.
            if ((bus.set_req_valid && bus.set_req_ready) || (bus.del_req_valid && bus.del_req_ready)) begin
                if (acc_log.size() == 0) begin
                    check_eq("issue_without_accept", 1, 0);
                end else begin
                    x = acc_log.pop_front();
                    check_eq("issue_order_op", bus.set_req_valid, x.op);
                    check_eq("issue_order_head", bus.set_req_valid ? bus.set_req_head : bus.del_req_head, x.head);
                    if (x.op) check_eq("issue_order_data", bus.set_req_data, x.data);
                end
            end
        end
        prev_set_vld  = bus.set_req_valid;
        prev_set_head = bus.set_req_head;
        prev_set_data = bus.set_req_data;
        prev_del_vld  = bus.del_req_valid;
        prev_del_head = bus.del_req_head;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            acc_log.delete();
            cur_vld      = 0;
            mrr          = 0;
            model_ok     = 1;
            prev_set_vld = 0;
            prev_del_vld = 0;
        end else begin
            done = cur_vld && (cur.op ? bus.set_req_ready : bus.del_req_ready);
            popd = !cur_vld && (mq.size() > 0);
            if (done) cur_vld = 0;
            if (popd) begin
                cur     = mq.pop_front();
                cur_vld = 1;
            end
            if (ef || ei) begin
                e.op   = ef;
                e.head = ef ? bus.fill_head : bus.inv_head;
                e.data = ef ? bus.fill_data : '0;
                mq.push_back(e);
                acc_log.push_back(e);
                mrr = ei;
                acc_n++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.fill_valid    = 0;
        bus.inv_valid     = 0;
        bus.set_req_ready = 0;
        bus.del_req_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        cycle();
        rst = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        bit seen;
        checks       = 0;
        failures     = 0;
        model_ok     = 0;
        cur_vld      = 0;
        mrr          = 0;
        acc_n        = 0;
        prev_set_vld = 0;
        prev_del_vld = 0;
        rst          = 0;
        bus.fill_head = '0;
        bus.fill_data = '0;
        bus.inv_head  = '0;
        idle_inputs();
        @(negedge clk);
        cycle();
        do_reset();

        // Reset state
        check_eq("rst_queue_count", bus.queue_count, 0);
        check_eq("rst_set_valid", bus.set_req_valid, 0);
        check_eq("rst_del_valid", bus.del_req_valid, 0);
        check_eq("rst_set_head", bus.set_req_head, 0);

        // Single fill: issued two cycles after acceptance
        bus.fill_valid = 1;
        bus.fill_head  = 64'h40;
        bus.fill_data  = {8{32'hA5A5_A5A5}};
        #1 check_eq("t1_fill_ready", bus.fill_ready, 1);
        cycle();
        bus.fill_valid = 0;
        check_eq("t1_count_one", bus.queue_count, 1);
        check_eq("t1_valid_low", bus.set_req_valid, 0);
        cycle();
        check_eq("t1_valid_high", bus.set_req_valid, 1);
        check_eq("t1_head", bus.set_req_head, 64'h40);
        check_eq("t1_data", bus.set_req_data, {8{32'hA5A5_A5A5}});
        check_eq("t1_count_zero", bus.queue_count, 0);
        bus.set_req_ready = 1;
        cycle();
        bus.set_req_ready = 0;
        check_eq("t1_valid_drop", bus.set_req_valid, 0);
        cycle();

        // Simultaneous fill and invalidate after reset: inv wins first
        do_reset();
        bus.fill_valid = 1;
        bus.fill_head  = 64'h80;
        bus.fill_data  = rnd_data();
        bus.inv_valid  = 1;
        bus.inv_head   = 64'hC0;
        #1;
        check_eq("t2_inv_first", bus.inv_ready, 1);
        check_eq("t2_fill_waits", bus.fill_ready, 0);
        cycle();
        #1;
        check_eq("t2_fill_second", bus.fill_ready, 1);
        check_eq("t2_inv_waits", bus.inv_ready, 0);
        cycle();
        bus.fill_valid = 0;
        bus.inv_valid  = 0;
        check_eq("t2_del_issued", bus.del_req_valid, 1);
        check_eq("t2_del_head", bus.del_req_head, 64'hC0);
        bus.del_req_ready = 1;
        cycle();
        bus.del_req_ready = 0;
        cycle();
        check_eq("t2_set_issued", bus.set_req_valid, 1);
        check_eq("t2_set_head", bus.set_req_head, 64'h80);
        bus.set_req_ready = 1;
        cycle();
        bus.set_req_ready = 0;
        cycle();

        // Fill with invalidates while the thread stalls
        do_reset();
        n = 0;
        bus.inv_valid = 1;
        for (int i = 0; i < 20; i++) begin
            bus.inv_head = rnd_head();
            #1 seen = bus.inv_ready;
            cycle();
            if (!seen) break;
            n++;
        end
        check_eq("t3_accepted", n, DEPTH + 1);
        check_eq("t3_count_full", bus.queue_count, DEPTH);
        check_eq("t3_del_held", bus.del_req_valid, 1);
        bus.del_req_ready = 1;
        #1 check_eq("t3_full_ready_cycle", bus.inv_ready, 0);
        cycle();
        bus.del_req_ready = 0;
        #1 check_eq("t3_no_write_through", bus.inv_ready, 0);
        cycle();
        #1 check_eq("t3_slot_freed", bus.inv_ready, 1);
        // Spurious set ready while a del is outstanding
        bus.set_req_ready = 1;
        cycle();
        bus.set_req_ready = 0;
        bus.inv_valid     = 0;
        check_eq("t4_del_still_valid", bus.del_req_valid, 1);
        cycle();
        check_eq("t4_del_still_valid2", bus.del_req_valid, 1);

        // Reset while a set is outstanding with three entries queued
        do_reset();
        bus.fill_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.fill_head = rnd_head();
            bus.fill_data = rnd_data();
            cycle();
        end
        bus.fill_valid = 0;
        check_eq("t5_set_outstanding", bus.set_req_valid, 1);
        check_eq("t5_three_queued", bus.queue_count, 3);
        do_reset();
        check_eq("t5_rst_count", bus.queue_count, 0);
        check_eq("t5_rst_set_valid", bus.set_req_valid, 0);
        check_eq("t5_rst_set_head", bus.set_req_head, 0);
        check_eq("t5_rst_set_data", bus.set_req_data, 0);
        check_eq("t5_rst_del_valid", bus.del_req_valid, 0);
        for (int i = 0; i < 5; i++) cycle();
        check_eq("t5_no_reissue", bus.set_req_valid || bus.del_req_valid, 0);

        // Random interleaved traffic with random thread response delay
        acc_n = 0;
        cyc   = 0;
        while (acc_n < 1000 && cyc < 20000) begin
            bus.fill_valid    = ($urandom_range(0, 9) < 4);
            bus.fill_head     = rnd_head();
            bus.fill_data     = rnd_data();
            bus.inv_valid     = ($urandom_range(0, 9) < 4);
            bus.inv_head      = rnd_head();
            bus.set_req_ready = ($urandom_range(0, 2) == 0);
            bus.del_req_ready = ($urandom_range(0, 2) == 0);
            cycle();
            cyc++;
        end
        check_eq("rand_accept_budget", (acc_n >= 1000), 1);
        bus.fill_valid    = 0;
        bus.inv_valid     = 0;
        bus.set_req_ready = 1;
        bus.del_req_ready = 1;
        n = 0;
        while ((bus.queue_count != 0 || bus.set_req_valid || bus.del_req_valid) && n < 200) begin
            cycle();
            n++;
        end
        idle_inputs();
        cycle();
        check_eq("drain_count", bus.queue_count, 0);
        check_eq("drain_idle", bus.set_req_valid || bus.del_req_valid, 0);
        check_eq("scoreboard_leftover", acc_log.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
